fetch_prefetch: RTL and testbench

Parametrised instruction-fetch front end replacing the single-cycle fetch stage.
- Generates the PC and issues requests to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned {pc, inst} pairs in a QDEPTH-entry queue and hands them to decode over a valid/ready handshake.
- Redirects (branch/jump resolution) flush the queue and squash in-flight responses.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_prefetch.sv | 116 +++++++++++
 tb/tb_fetch_prefetch.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and RV32I constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [XLEN_DEFAULT-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries with a single-cycle flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem[head_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // The fetch credit scheme must make an overfilling push unreachable.
  push_while_full: assert property (@(posedge clk) disable iff (rst || flush) !(push && full));

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage: PC generation, credit-limited issue, response queueing.
// Optional macro FETCH_PERF_EN enables the three performance counters.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_DEFAULT,
  parameter int              IMEM_DEPTH = 32,
  parameter int              QDEPTH     = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic                          imem_req,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [XLEN-1:0]               imem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_inst,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   perf_fetched,
  output logic [31:0]                   perf_squashed,
  output logic [31:0]                   perf_stall
);

  localparam int AW  = $clog2(IMEM_DEPTH);
  localparam int CW  = $clog2(QDEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            pop;
  logic            push;
  logic [CW1-1:0]  credit_used;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            unused_bits;

  // Slots that will be occupied once everything already requested has landed.
  assign credit_used = {1'b0, count} - CW1'(pop) + CW1'(inflight);
  assign imem_req    = !rst && !redirect_valid && (credit_used < CW1'(QDEPTH));
  assign imem_addr   = fetch_pc[AW+1:2];

  assign out_valid = !rst && !empty && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push      = inflight && !redirect_valid;
  assign out_pc    = head.pc;
  assign out_inst  = head.inst;

  assign push_entry.pc   = inflight_pc;
  assign push_entry.inst = imem_rdata;
  assign unused_bits     = ^{redirect_pc[1:0], full};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q;
  logic [31:0] squashed_q;
  logic [31:0] stall_q;

  // A redirect discards both queued entries and the response still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetched_q  <= '0;
      squashed_q <= '0;
      stall_q    <= '0;
    end else begin
      if (pop)            fetched_q  <= fetched_q + 32'd1;
      if (redirect_valid) squashed_q <= squashed_q + 32'(count) + 32'(inflight);
      if (!imem_req)      stall_q    <= stall_q + 32'd1;
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
  assign perf_stall    = stall_q;
`else
  assign perf_fetched  = '0;
  assign perf_squashed = '0;
  assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Scenario bench for fetch_prefetch with an imem model returning (word index << 8).
module tb_fetch_prefetch;
  import fetch_pkg::*;

  localparam int          XLEN       = 32;
  localparam int          IMEM_DEPTH = 32;
  localparam int          QDEPTH     = 4;
  localparam int          AW         = 5;
  localparam logic [31:0] RESET_PC   = 32'h0;

`ifdef FETCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_squashed;
  logic [31:0]   perf_stall;

  int n_checks = 0;
  int n_pass   = 0;
  fetch_entry_t sb[$];

  fetch_prefetch #(
    .XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .perf_fetched(perf_fetched), .perf_squashed(perf_squashed), .perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= 32'(imem_addr) << 8;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
    return ((pc >> 2) & 32'(IMEM_DEPTH - 1)) << 8;
  endfunction

  task automatic load_stream(input logic [31:0] pc, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) begin
      fetch_entry_t e;
      e.pc   = pc + 32'(4 * i);
      e.inst = exp_inst(e.pc);
      sb.push_back(e);
    end
  endtask

  function automatic fetch_entry_t sb_next();
    fetch_entry_t e;
    e.pc   = 32'hFFFF_FFFF;
    e.inst = 32'hFFFF_FFFF;
    if (sb.size() != 0) e = sb.pop_front();
    return e;
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
  endtask

  task automatic test_reset();
    fetch_entry_t e;
    int first;
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0)
      $display("[TB] FAIL reset_outputs: imem_req=%b out_valid=%b expected 0 0", imem_req, out_valid);
    else n_pass++;
    n_checks++;
    if ({perf_fetched, perf_squashed, perf_stall} !== 96'h0)
      $display("[TB] FAIL reset_perf: %h %h %h expected all 0", perf_fetched, perf_squashed, perf_stall);
    else n_pass++;
    load_stream(RESET_PC, 64);
    first = -1;
    for (int i = 0; i < 6 && first < 0; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1) first = i;
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL reset_stream: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
    n_checks++;
    if (first != 2) $display("[TB] FAIL first_valid_latency: got %0d expected 2", first);
    else n_pass++;
  endtask

  task automatic test_stream();
    fetch_entry_t e;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1) $display("[TB] FAIL stream_throughput: out_valid=%b expected 1 at cycle %0d", out_valid, i);
      else n_pass++;
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL stream_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    fetch_entry_t e;
    int reqs;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    load_stream(RESET_PC, 64);
    reqs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      if (imem_req === 1'b1) reqs++;
    end
    n_checks++;
    if (reqs != QDEPTH) $display("[TB] FAIL bp_requests: got %0d expected %0d", reqs, QDEPTH);
    else n_pass++;
    n_checks++;
    if (imem_req !== 1'b0 || out_valid !== 1'b1 || dut.count !== 3'd4)
      $display("[TB] FAIL bp_full: imem_req=%b out_valid=%b count=%0d expected 0 1 4", imem_req, out_valid, dut.count);
    else n_pass++;
    n_checks++;
    if (perf_stall !== (PERF_ON ? 32'd3 : 32'd0))
      $display("[TB] FAIL bp_stall_count: got %0d expected %0d", perf_stall, PERF_ON ? 3 : 0);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1) $display("[TB] FAIL bp_resume_gap: out_valid=%b expected 1 at cycle %0d", out_valid, i);
      else n_pass++;
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL bp_resume_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
  endtask

  task automatic test_redirect();
    fetch_entry_t e;
    int first;
    logic [31:0] squash_before;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h40, 1'b1);
    squash_before = perf_squashed;
    n_checks++;
    if (dut.count !== 3'd3 || dut.inflight !== 1'b1)
      $display("[TB] FAIL redirect_setup: count=%0d inflight=%b expected 3 1", dut.count, dut.inflight);
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0)
      $display("[TB] FAIL redirect_cycle: out_valid=%b imem_req=%b expected 0 0", out_valid, imem_req);
    else n_pass++;
    load_stream(32'h40, 64);
    first = -1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid === 1'b1 && first < 0) first = i;
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL redirect_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
    n_checks++;
    if (first != 2) $display("[TB] FAIL redirect_latency: first valid at +%0d expected +3", first + 1);
    else n_pass++;
    n_checks++;
    if (perf_squashed - squash_before !== (PERF_ON ? 32'd4 : 32'd0))
      $display("[TB] FAIL redirect_squashed: delta %0d expected %0d", perf_squashed - squash_before, PERF_ON ? 4 : 0);
    else n_pass++;
  endtask

  task automatic test_misaligned();
    fetch_entry_t e;
    drive(1'b0, 1'b1, 32'h7F, 1'b1);
    load_stream(32'h7C, 64);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd31)
      $display("[TB] FAIL misaligned_addr: req=%b addr=%0d expected 1 31", imem_req, imem_addr);
    else n_pass++;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 5'd0)
      $display("[TB] FAIL addr_wrap: req=%b addr=%0d expected 1 0", imem_req, imem_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL misaligned_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    fetch_entry_t e;
    drive(1'b0, 1'b1, 32'h20, 1'b1);
    drive(1'b0, 1'b1, 32'h30, 1'b1);
    load_stream(32'h30, 64);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL b2b_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || dut.count !== 3'd4)
      $display("[TB] FAIL prereset_full: out_valid=%b count=%0d expected 1 4", out_valid, dut.count);
    else n_pass++;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b0)
      $display("[TB] FAIL midreset_outputs: out_valid=%b imem_req=%b expected 0 0", out_valid, imem_req);
    else n_pass++;
    load_stream(RESET_PC, 64);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 5'd0)
      $display("[TB] FAIL midreset_restart: valid=%b req=%b addr=%0d expected 0 1 0", out_valid, imem_req, imem_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      if (out_valid && out_ready) begin
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL midreset_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    fetch_entry_t e;
    int popped;
    logic rv;
    logic rdy;
    logic [31:0] rpc;
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    load_stream(RESET_PC, 1100);
    popped = 0;
    for (int i = 0; i < 1000; i++) begin
      rv  = ($urandom_range(0, 99) < 2);
      rdy = 1'($urandom_range(0, 1));
      rpc = $urandom;
      drive(1'b0, rv, rpc, rdy);
      if (out_valid && out_ready) begin
        popped++;
        e = sb_next(); n_checks++;
        if (out_pc !== e.pc || out_inst !== e.inst)
          $display("[TB] FAIL random_data: pc=%h inst=%h expected pc=%h inst=%h", out_pc, out_inst, e.pc, e.inst);
        else n_pass++;
      end
      if (rv) load_stream({rpc[31:2], 2'b00}, 1100);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    n_checks++;
    if (perf_fetched !== (PERF_ON ? 32'(popped) : 32'd0))
      $display("[TB] FAIL random_perf_fetched: got %0d expected %0d", perf_fetched, PERF_ON ? popped : 0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
